// File: rtl/cmlk_timing_pkg.sv
// Shared types for the CameraLink timing generator blocks.
package cmlk_timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } pulse_state_t;

    localparam int OVR_CNT_W = 16;

endpackage

// File: rtl/trig_pulse_gen_if.sv
// Control/status bundle of the trigger pulse generator.
// master drives triggers and config, slave is the generator itself.
interface trig_pulse_gen_if #(
    parameter int CNT_W = 32
);
    import cmlk_timing_pkg::*;

    logic                 enable;
    logic                 trig;
    logic [CNT_W-1:0]     delay_cfg;
    logic [CNT_W-1:0]     width_cfg;
    logic                 pulse_out;
    logic                 busy;
    logic                 done;
    logic                 trig_ovr;
    logic [OVR_CNT_W-1:0] ovr_cnt;

    modport master (
        output enable, trig, delay_cfg, width_cfg,
        input  pulse_out, busy, done, trig_ovr, ovr_cnt
    );

    modport slave (
        input  enable, trig, delay_cfg, width_cfg,
        output pulse_out, busy, done, trig_ovr, ovr_cnt
    );

endinterface

// File: rtl/trig_delay_counter.sv
// Load/decrement down-counter with a zero flag. Shared by the delay and
// pulse phases: the FSM loads N-1 on phase entry and leaves the phase on
// the edge where the counter reads zero, giving exactly N cycles.
module trig_delay_counter
    import cmlk_timing_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/trig_pulse_gen.sv
// Trigger-to-pulse generator: per accepted trigger, wait delay_cfg cycles
// then drive pulse_out active for width_cfg cycles. Triggers arriving
// while a sequence runs are dropped and flagged on trig_ovr.
// Optional: define TRIG_OVR_CNT_EN to keep a saturating rejected-trigger
// count on ovr_cnt; otherwise ovr_cnt is tied to zero.
module trig_pulse_gen
    import cmlk_timing_pkg::*;
#(
    parameter int   CNT_W   = 32,
    parameter logic OUT_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    trig_pulse_gen_if.slave  bus
);

    pulse_state_t     state_q;
    logic [CNT_W-1:0] width_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;
    logic             ovr_q;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             ovr_set;

    // A trigger is an overrun only when enabled and a sequence is running.
    assign ovr_set = bus.enable && bus.trig && (state_q != IDLE);

    // Counter control: load N-1 on entry to each timed phase, else count down.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        if (bus.enable) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.trig && (bus.delay_cfg != '0)) begin
                        cnt_load = 1'b1;
                        cnt_val  = bus.delay_cfg - CNT_W'(1);
                    end else if (bus.trig && (bus.width_cfg != '0)) begin
                        cnt_load = 1'b1;
                        cnt_val  = bus.width_cfg - CNT_W'(1);
                    end
                end
                DELAY: begin
                    if (cnt_zero) begin
                        if (width_q != '0) begin
                            cnt_load = 1'b1;
                            cnt_val  = width_q - CNT_W'(1);
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                PULSE: begin
                    if (!cnt_zero) cnt_dec = 1'b1;
                end
                default: ;
            endcase
        end
    end

    trig_delay_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Sequencer FSM with registered outputs; width is latched at acceptance
    // so config changes mid-sequence have no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            width_q <= '0;
            pulse_q <= ~OUT_POL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= ovr_set;
            if (!bus.enable) begin
                state_q <= IDLE;
                pulse_q <= ~OUT_POL;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.trig) begin
                            width_q <= bus.width_cfg;
                            if (bus.delay_cfg != '0) begin
                                state_q <= DELAY;
                                busy_q  <= 1'b1;
                            end else if (bus.width_cfg != '0) begin
                                state_q <= PULSE;
                                busy_q  <= 1'b1;
                                pulse_q <= OUT_POL;
                            end else begin
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    DELAY: begin
                        if (cnt_zero) begin
                            if (width_q != '0) begin
                                state_q <= PULSE;
                                pulse_q <= OUT_POL;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    PULSE: begin
                        if (cnt_zero) begin
                            state_q <= IDLE;
                            pulse_q <= ~OUT_POL;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        pulse_q <= ~OUT_POL;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TRIG_OVR_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt_q;

    // Saturating count of rejected triggers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr_cnt_q <= '0;
        else if (ovr_set && (ovr_cnt_q != '1))
            ovr_cnt_q <= ovr_cnt_q + OVR_CNT_W'(1);
    end

    assign bus.ovr_cnt = ovr_cnt_q;
`else
    assign bus.ovr_cnt = '0;
`endif

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.trig_ovr  = ovr_q;

endmodule
